// File: rtl/td4_pkg.sv
// Shared TD4 definitions: instruction field widths, sequencer states and ISA opcodes.
package td4_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned IMM_W   = 4;
  localparam int unsigned PC_W    = 4;
  localparam int unsigned INSTR_W = OPC_W + IMM_W;
  localparam int unsigned DEPTH   = 1 << PC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } seq_state_e;

  // TD4 opcodes, shared with the core's decoder.
  localparam logic [OPC_W-1:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [OPC_W-1:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_IN_A     = 4'b0010;
  localparam logic [OPC_W-1:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [OPC_W-1:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [OPC_W-1:0] OP_IN_B     = 4'b0110;
  localparam logic [OPC_W-1:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [OPC_W-1:0] OP_OUT_B    = 4'b1001;
  localparam logic [OPC_W-1:0] OP_OUT_IM   = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JNC      = 4'b1110;
  localparam logic [OPC_W-1:0] OP_JMP      = 4'b1111;

endpackage

// File: rtl/td4_prog_mem.sv
// 16x8 program store: one synchronous write port, one combinational read port,
// every entry cleared by the asynchronous reset.
module td4_prog_mem
  import td4_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [PC_W-1:0]    waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [PC_W-1:0]    raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/td4_sequencer.sv
// Run-control for the TD4 core: program load port, run/step/halt FSM,
// single hardware breakpoint and a saturating executed-instruction counter.
module td4_sequencer
  import td4_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               run_req,
  input  logic               step_req,
  input  logic               halt_req,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  input  logic [PC_W-1:0]    pc_in,
  output logic [OPC_W-1:0]   opcode,
  output logic [IMM_W-1:0]   immediate,
  output logic               cpu_en,
  output logic [1:0]         state_o,
  output logic [7:0]         exec_count
);

  seq_state_e         state_q, state_d;
  logic               skip_bp_q, skip_bp_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               bp_hit;
  logic               mem_we;
  logic [INSTR_W-1:0] instr;

  assign load_ready = (state_q != RUN);
  assign mem_we     = load_valid && load_ready;

  td4_prog_mem u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (pc_in),
    .rdata_o (instr)
  );

  assign opcode    = instr[INSTR_W-1:IMM_W];
  assign immediate = instr[IMM_W-1:0];

  assign bp_hit = (state_q == RUN) && bp_en && (pc_in == bp_addr) && !skip_bp_q;
  assign cpu_en = ((state_q == RUN) && !bp_hit) || (state_q == STEP);

  always_comb begin
    state_d   = state_q;
    skip_bp_d = skip_bp_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE, BREAK: begin
        if (halt_req) begin
          state_d = IDLE;
        end else if (step_req) begin
          state_d = STEP;
        end else if (run_req) begin
          state_d = RUN;
        end
        // Resuming from a breakpoint must execute the breakpointed instruction once.
        if (state_q == BREAK && !halt_req && (step_req || run_req)) begin
          skip_bp_d = 1'b1;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d = IDLE;
        end else if (bp_hit) begin
          state_d = BREAK;
        end
      end
      STEP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cpu_en) begin
      skip_bp_d = 1'b0;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      skip_bp_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      skip_bp_q <= skip_bp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state_o    = state_q;
  assign exec_count = cnt_q;

endmodule
